hex_keypad_entry: RTL and testbench

HEX_KEYPAD_ENTRY -- requirements
Module: hex_keypad_entry

---
 rtl/hex_keypad_entry.sv | 168 ++++++++++++++++
 tb/tb_hex_keypad_entry.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner with debounce and a four-digit entry shift register.
// Define KEYPAD_AUTOREPEAT_EN to emit repeat key events while a key stays held.
module hex_keypad_entry #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_CNT   = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row_i,
  input  logic        clear_i,
  output logic [3:0]  col_o,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] value_q
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_CNT + 1);

  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_CNT < 1) begin : g_bad_params
    $error("hex_keypad_entry: SCAN_DIV >= 4, DEBOUNCE_CNT >= 1, REPEAT_CNT >= 1 required");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t        state;
  logic [3:0]    row_meta;
  logic [3:0]    row_s;
  logic [3:0]    pattern;
  logic [SW-1:0] slot;
  logic [1:0]    col_idx;
  logic [1:0]    row_idx;
  logic [1:0]    low_idx;
  logic [DW-1:0] match_cnt;
  logic [DW-1:0] release_cnt;
  logic          one_low;
  logic          sample;
  logic [3:0]    press_code;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CNT + 1);
  logic [RW-1:0] repeat_cnt;
`endif

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    one_low = 1'b1;
    low_idx = 2'd0;
    case (row_s)
      4'b1110: low_idx = 2'd0;
      4'b1101: low_idx = 2'd1;
      4'b1011: low_idx = 2'd2;
      4'b0111: low_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  assign sample     = (slot == SW'(SCAN_DIV - 1));
  assign press_code = (state == SCAN) ? {low_idx, col_idx} : {row_idx, col_idx};
  assign col_o      = ~(4'b0001 << col_idx);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SCAN;
      row_meta    <= 4'hF;
      row_s       <= 4'hF;
      pattern     <= 4'hF;
      slot        <= '0;
      col_idx     <= 2'd0;
      row_idx     <= 2'd0;
      match_cnt   <= '0;
      release_cnt <= '0;
      key_valid   <= 1'b0;
      key_code    <= 4'h0;
      value_q     <= 16'h0000;
`ifdef KEYPAD_AUTOREPEAT_EN
      repeat_cnt  <= '0;
`endif
    end else begin
      row_meta  <= row_i;
      row_s     <= row_meta;
      key_valid <= 1'b0;
      slot      <= sample ? '0 : slot + SW'(1);

      if (sample) begin
        case (state)
          SCAN: begin
            if (one_low) begin
              row_idx   <= low_idx;
              pattern   <= row_s;
              match_cnt <= DW'(1);
              if (DEBOUNCE_CNT == 1) begin
                state       <= HELD;
                release_cnt <= '0;
                key_valid   <= 1'b1;
                key_code    <= press_code;
                value_q     <= {value_q[11:0], press_code};
`ifdef KEYPAD_AUTOREPEAT_EN
                repeat_cnt  <= '0;
`endif
              end else begin
                state <= DEBOUNCE;
              end
            end else begin
              col_idx <= col_idx + 2'd1;
            end
          end

          DEBOUNCE: begin
            if (row_s == pattern) begin
              if (match_cnt == DW'(DEBOUNCE_CNT - 1)) begin
                state       <= HELD;
                match_cnt   <= '0;
                release_cnt <= '0;
                key_valid   <= 1'b1;
                key_code    <= press_code;
                value_q     <= {value_q[11:0], press_code};
`ifdef KEYPAD_AUTOREPEAT_EN
                repeat_cnt  <= '0;
`endif
              end else begin
                match_cnt <= match_cnt + DW'(1);
              end
            end else begin
              state     <= SCAN;
              match_cnt <= '0;
              col_idx   <= col_idx + 2'd1;
            end
          end

          HELD: begin
            // Any low row counts as still pressed; only a full release rearms detection.
            if (row_s == 4'hF) begin
              if (release_cnt == DW'(DEBOUNCE_CNT - 1)) begin
                state       <= SCAN;
                release_cnt <= '0;
              end else begin
                release_cnt <= release_cnt + DW'(1);
              end
`ifdef KEYPAD_AUTOREPEAT_EN
              repeat_cnt <= '0;
`endif
            end else begin
              release_cnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              if (repeat_cnt == RW'(REPEAT_CNT - 1)) begin
                repeat_cnt <= '0;
                key_valid  <= 1'b1;
                value_q    <= {value_q[11:0], key_code};
              end else begin
                repeat_cnt <= repeat_cnt + RW'(1);
              end
`endif
            end
          end

          default: state <= SCAN;
        endcase
      end

      // NOTE: the last non-blocking assignment wins, so clear overrides a same-edge shift.
      if (clear_i) value_q <= 16'h0000;
    end
  end

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Self-checking bench for hex_keypad_entry: keypad matrix model, behavioural
// reference checked every cycle, directed scenarios plus randomized presses.
module tb_hex_keypad_entry;

  localparam int SD  = 4;
  localparam int DEB = 2;
  localparam int REP = 3;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int        EXP_HOLD_PULSES = 4;
  localparam bit [15:0] EXP_HOLD_VALUE  = 16'h3333;
`else
  localparam int        EXP_HOLD_PULSES = 1;
  localparam bit [15:0] EXP_HOLD_VALUE  = 16'h0003;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_i;
  logic [3:0]  row_i;
  logic [3:0]  col_o;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] value_q;
  logic [15:0] pressed;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  hex_keypad_entry #(
    .SCAN_DIV    (SD),
    .DEBOUNCE_CNT(DEB),
    .REPEAT_CNT  (REP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row_i    (row_i),
    .clear_i  (clear_i),
    .col_o    (col_o),
    .key_valid(key_valid),
    .key_code (key_code),
    .value_q  (value_q)
  );

  always #5 clk = ~clk;

  // Key k sits at row k/4, column k%4; a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_i = 4'hF;
    for (int k = 0; k < 16; k++)
      if (pressed[k] && !col_o[k % 4]) row_i[k / 4] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sampling time from cycle count, key tracking as plain flags and streaks.
  int         m_cyc, m_col, m_row, m_streak, m_rel, m_rep, m_value, m_nlow, m_idx;
  bit         m_cand, m_hold, m_valid, m_accept;
  logic [3:0] m_s1, m_s2, m_pat, m_code, m_smp;

  task automatic model_reset();
    m_cyc = 0; m_col = 0; m_row = 0; m_streak = 0; m_rel = 0; m_rep = 0; m_value = 0;
    m_cand = 0; m_hold = 0; m_valid = 0;
    m_s1 = 4'hF; m_s2 = 4'hF; m_pat = 4'hF; m_code = 4'h0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        model_reset();
      end else begin
        m_valid  = 0;
        m_accept = 0;
        m_smp    = m_s2;
        if (m_cyc % SD == SD - 1) begin
          m_nlow = 0;
          m_idx  = 0;
          for (int r = 0; r < 4; r++)
            if (!m_smp[r]) begin m_nlow++; m_idx = r; end
          if (m_hold) begin
            if (m_smp == 4'hF) begin
              m_rep = 0;
              m_rel++;
              if (m_rel == DEB) begin m_hold = 0; m_rel = 0; end
            end else begin
              m_rel = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
              m_rep++;
              if (m_rep == REP) begin m_rep = 0; m_accept = 1; end
`endif
            end
          end else if (m_cand) begin
            if (m_smp == m_pat) begin
              m_streak++;
              if (m_streak == DEB) begin
                m_accept = 1;
                m_code   = 4'(m_row * 4 + m_col);
                m_cand   = 0;
                m_hold   = 1;
                m_rel    = 0;
                m_rep    = 0;
              end
            end else begin
              m_cand = 0;
              m_col  = (m_col + 1) % 4;
            end
          end else if (m_nlow == 1) begin
            m_pat    = m_smp;
            m_row    = m_idx;
            m_streak = 1;
            if (DEB == 1) begin
              m_accept = 1;
              m_code   = 4'(m_row * 4 + m_col);
              m_hold   = 1;
              m_rel    = 0;
              m_rep    = 0;
            end else begin
              m_cand = 1;
            end
          end else begin
            m_col = (m_col + 1) % 4;
          end
        end
        if (m_accept) begin
          m_valid = 1;
          m_value = (m_value * 16 + m_code) % 65536;
        end
        if (clear_i) m_value = 0;
        m_s2 = m_s1;
        m_s1 = row_i;
        m_cyc++;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("col_o", col_o, 15 - (1 << m_col));
        check("key_valid", key_valid, m_valid);
        check("key_code", key_code, m_code);
        check("value_q", value_q, m_value);
        if (key_valid === 1'b1) pulses++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int code);
    pressed = 16'b1 << code;
  endtask

  task automatic wait_pulse(input string name, input int budget);
    int n = 0;
    while (key_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (key_valid !== 1'b1) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_cand(input string name, input int budget);
    int n = 0;
    while (!m_cand && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!m_cand) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    clear_i = 1'b0;
    pressed = 16'h0000;
    tick(3);
    check("rst_col_o", col_o, 4'b1110);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_code", key_code, 4'h0);
    check("rst_value_q", value_q, 16'h0000);

    // Idle scanning: one column per sample period.
    reset = 1'b0;
    tick(1);  check("scan_col0", col_o, 4'b1110);
    tick(4);  check("scan_col1", col_o, 4'b1101);
    tick(4);  check("scan_col2", col_o, 4'b1011);
    tick(4);  check("scan_col3", col_o, 4'b0111);
    tick(16);
    check("idle_pulses", pulses, 0);
    check("idle_value", value_q, 16'h0000);

    // Row 2 / column 1 gives code 9; column stays frozen while held.
    pulses = 0;
    press(9);
    wait_pulse("key9", 200);
    check("key9_code", key_code, 4'h9);
    check("key9_value", value_q, 16'h0009);
    tick(20);
    check("key9_col_frozen", col_o, 4'b1101);
    pressed = 16'h0000;
    tick(16);
    check("key9_pulses", pulses, 1);

    // Five keys with full releases: oldest digits fall off the top.
    for (int k = 1; k <= 5; k++) begin
      press(k);
      wait_pulse("seq", 200);
      tick(8);
      pressed = 16'h0000;
      tick(16);
    end
    check("seq_value", value_q, 16'h2345);

    // One-sample bounce during debounce, then a stable press.
    pulses = 0;
    press(7);
    wait_cand("bounce_cand", 200);
    pressed = 16'h0000;
    tick(SD);
    press(7);
    wait_pulse("bounce", 200);
    tick(4);
    pressed = 16'h0000;
    tick(16);
    check("bounce_pulses", pulses, 1);
    check("bounce_code", key_code, 4'h7);

    // Clear held across the accepting edge: code updates, value stays zero.
    clear_i = 1'b1;
    press(10);
    wait_pulse("clear_hit", 200);
    check("clear_hit_valid", key_valid, 1'b1);
    check("clear_hit_code", key_code, 4'hA);
    check("clear_hit_value", value_q, 16'h0000);
    clear_i = 1'b0;
    pressed = 16'h0000;
    tick(16);

    // Key 3 held twelve samples (detect, accept, ten more held samples).
    pulses = 0;
    press(3);
    wait_pulse("hold3", 200);
    tick(10 * SD);
    pressed = 16'h0000;
    tick(16);
    check("hold3_pulses", pulses, EXP_HOLD_PULSES);
    check("hold3_value", value_q, EXP_HOLD_VALUE);

    // Reset while held: no pulse during reset, still-held key detected afresh.
    press(5);
    wait_pulse("held_rst_pre", 200);
    tick(6);
    reset = 1'b1;
    tick(2);
    check("held_rst_valid", key_valid, 1'b0);
    check("held_rst_value", value_q, 16'h0000);
    reset  = 1'b0;
    pulses = 0;
    wait_pulse("held_rst_post", 200);
    check("held_rst_code", key_code, 4'h5);
    check("held_rst_new_value", value_q, 16'h0005);
    pressed = 16'h0000;
    tick(16);

    // Reset while debouncing: that press is aborted, then re-detected.
    pulses = 0;
    press(14);
    wait_cand("deb_rst_cand", 200);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("deb_rst_pulses", pulses, 0);
    wait_pulse("deb_rst_post", 200);
    check("deb_rst_code", key_code, 4'hE);
    check("deb_rst_value", value_q, 16'h000E);
    pressed = 16'h0000;
    tick(16);

    // Randomized presses, chords, short taps, clears and occasional resets.
    for (int it = 0; it < 60; it++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 7)
        pressed = 16'b1 << $urandom_range(0, 15);
      else if (kind < 9)
        pressed = (16'b1 << $urandom_range(0, 15)) | (16'b1 << $urandom_range(0, 15));
      else
        pressed = 16'h0000;
      repeat ($urandom_range(1, 60)) begin
        clear_i = ($urandom_range(0, 15) == 0);
        @(negedge clk);
      end
      clear_i = 1'b0;
      pressed = 16'h0000;
      if (it % 20 == 19) begin
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
      end
      tick($urandom_range(1, 30));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
